// File: rtl/fma_normalizer.sv
// fma_normalizer: post-addition normalize-and-round stage of the FMA datapath.
// Leading-zero counts the 75-bit sum magnitude, left-normalizes it, rounds to
// nearest-even and packs an IEEE-754 result with overflow/underflow/inexact.
// Three register stages under a single global stall (en = ~valid_o | ready_i).
// Optional feature macro: FMA_SUBNORMAL_EN (gradual underflow). When it is not
// defined, every beat whose exponent would fall below 1 flushes to signed zero.
module fma_normalizer #(
  parameter int PARM_EXP  = 8,
  parameter int PARM_MANT = 23,
  parameter int PARM_BIAS = 127
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  input  logic [3*PARM_MANT+5:0]        Sum_i,
  input  logic [PARM_EXP+1:0]           Exp_i,
  input  logic                          Sign_i,
  input  logic                          Sticky_i,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [PARM_EXP+PARM_MANT:0]   Result_o,
  output logic                          Overflow_o,
  output logic                          Underflow_o,
  output logic                          Inexact_o
);

  localparam int SUM_W   = 3*PARM_MANT+6;          // sum magnitude width
  localparam int EXP_IW  = PARM_EXP+2;             // incoming exponent width
  localparam int EW      = PARM_EXP+4;             // internal exponent width, wrap-free
  localparam int LZ_W    = $clog2(SUM_W+1);        // leading-zero count width
  localparam int MW      = PARM_MANT+2;            // rounded mantissa incl. carry
  localparam int LSB_POS = SUM_W-1-PARM_MANT;      // mantissa LSB after normalization
  localparam int ONE_POS = 2*PARM_MANT+1;          // bit weighted as 1.0 at Exp_i

  localparam logic signed [EW-1:0] ZERO_S    = '0;
  localparam logic signed [EW-1:0] ONE_S     = EW'(1);
  localparam logic signed [EW-1:0] E_OFS_S   = EW'(SUM_W-1-ONE_POS);
  localparam logic signed [EW-1:0] EXP_INF_S = EW'(2*PARM_BIAS+1);

  // Leading-zero count; an all-zero vector reports SUM_W.
  function automatic logic [LZ_W-1:0] count_lz(input logic [SUM_W-1:0] v);
    logic [LZ_W-1:0] n;
    n = LZ_W'(SUM_W);
    for (int i = 0; i < SUM_W; i++)
      if (v[i]) n = LZ_W'(SUM_W-1-i);
    return n;
  endfunction

  // Round-to-nearest-even on a normalized vector; result has the carry bit on top.
  function automatic logic [MW-1:0] rne_round(input logic [SUM_W-1:0] v,
                                               input logic sticky);
    logic l, g, s, up;
    l  = v[LSB_POS];
    g  = v[LSB_POS-1];
    s  = (|v[LSB_POS-2:0]) | sticky;
    up = g & (l | s);
    return {1'b0, v[SUM_W-1:LSB_POS]} + MW'(up);
  endfunction

  // Any discarded bit (guard, lower bits or aligner sticky) makes the result inexact.
  function automatic logic round_lost(input logic [SUM_W-1:0] v, input logic sticky);
    return v[LSB_POS-1] | (|v[LSB_POS-2:0]) | sticky;
  endfunction

  logic en;
  assign en      = ~valid_o | ready_i;
  assign ready_o = en;

  // ---------------- stage p0: capture inputs, leading-zero count ----------------
  logic                   vld_p0;
  logic [SUM_W-1:0]       sum_p0;
  logic signed [EW-1:0]   exp_p0;
  logic                   sign_p0, sticky_p0, zero_p0;
  logic [LZ_W-1:0]        lzc_p0;

  // Valid for stage p0 follows accepted input beats.
  always_ff @(posedge clk_i) begin
    if (rst_i)   vld_p0 <= 1'b0;
    else if (en) vld_p0 <= valid_i;
  end

  // Stage p0 data register.
  always_ff @(posedge clk_i) begin
    if (en) begin
      sum_p0    <= Sum_i;
      exp_p0    <= $signed({{(EW-EXP_IW){Exp_i[EXP_IW-1]}}, Exp_i});
      sign_p0   <= Sign_i;
      sticky_p0 <= Sticky_i;
      zero_p0   <= (Sum_i == '0);
      lzc_p0    <= count_lz(Sum_i);
    end
  end

  // ---------------- stage p1: shift amount and left normalization ----------------
  logic signed [EW-1:0]   lzc_s1, e_norm_s1, e_fin_s1;
  logic [LZ_W-1:0]        sh_s1;
  logic                   flush_s1;
  logic [SUM_W-1:0]       sum_sh_s1;
`ifdef FMA_SUBNORMAL_EN
  logic signed [EW-1:0]   sub_sh_s1;
`endif

  // Pick the shift: full normalization, clamped subnormal shift, or flush.
  always_comb begin
    lzc_s1    = $signed({{(EW-LZ_W){1'b0}}, lzc_p0});
    e_norm_s1 = exp_p0 + E_OFS_S - lzc_s1;
    sh_s1     = lzc_p0;
    flush_s1  = 1'b0;
`ifdef FMA_SUBNORMAL_EN
    sub_sh_s1 = exp_p0 + E_OFS_S - ONE_S;
    if (e_norm_s1 <= ZERO_S) begin
      if (sub_sh_s1 < ZERO_S)       flush_s1 = ~zero_p0;
      else if (sub_sh_s1 < lzc_s1)  sh_s1    = sub_sh_s1[LZ_W-1:0];
    end
`else
    flush_s1  = ~zero_p0 & (e_norm_s1 < ONE_S);
`endif
    e_fin_s1  = exp_p0 + E_OFS_S - $signed({{(EW-LZ_W){1'b0}}, sh_s1});
    sum_sh_s1 = sum_p0 << sh_s1;
  end

  logic                   vld_p1;
  logic [SUM_W-1:0]       sum_p1;
  logic signed [EW-1:0]   efin_p1;
  logic                   sign_p1, sticky_p1, zero_p1, flush_p1;

  // Valid for stage p1.
  always_ff @(posedge clk_i) begin
    if (rst_i)   vld_p1 <= 1'b0;
    else if (en) vld_p1 <= vld_p0;
  end

  // Stage p1 data register.
  always_ff @(posedge clk_i) begin
    if (en) begin
      sum_p1    <= sum_sh_s1;
      efin_p1   <= e_fin_s1;
      sign_p1   <= sign_p0;
      sticky_p1 <= sticky_p0;
      zero_p1   <= zero_p0;
      flush_p1  <= flush_s1;
    end
  end

  // ---------------- stage p2: round, pack, flags ----------------
  logic [MW-1:0]                 mant_s2;
  logic                          hidden_s2, lost_s2;
  logic signed [EW-1:0]          e_rnd_s2;
  logic [PARM_EXP+PARM_MANT:0]   res_s2;
  logic                          ov_s2, uf_s2, ix_s2;

  // Round, resolve exponent and select zero / flush / infinity / finite packing.
  always_comb begin
    mant_s2   = rne_round(sum_p1, sticky_p1);
    lost_s2   = round_lost(sum_p1, sticky_p1);
    hidden_s2 = mant_s2[MW-1] | mant_s2[MW-2];
    e_rnd_s2  = efin_p1 + $signed({{(EW-1){1'b0}}, mant_s2[MW-1]});
    res_s2    = {sign_p1, {(PARM_EXP+PARM_MANT){1'b0}}};
    ov_s2     = 1'b0;
    uf_s2     = 1'b0;
    ix_s2     = 1'b0;
    if (zero_p1) begin
      uf_s2 = sticky_p1;
      ix_s2 = sticky_p1;
    end else if (flush_p1) begin
      uf_s2 = 1'b1;
      ix_s2 = 1'b1;
    end else if (hidden_s2 && (e_rnd_s2 >= EXP_INF_S)) begin
      res_s2 = {sign_p1, {PARM_EXP{1'b1}}, {PARM_MANT{1'b0}}};
      ov_s2  = 1'b1;
      ix_s2  = 1'b1;
    end else begin
      res_s2 = {sign_p1,
                hidden_s2 ? e_rnd_s2[PARM_EXP-1:0] : {PARM_EXP{1'b0}},
                mant_s2[PARM_MANT-1:0]};
      ix_s2  = lost_s2;
      uf_s2  = ~hidden_s2 & lost_s2;
    end
  end

  logic                          vld_p2;
  logic [PARM_EXP+PARM_MANT:0]   res_p2;
  logic                          ov_p2, uf_p2, ix_p2;

  // Output register; cleared on reset so no stale result is visible.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p2 <= 1'b0;
      res_p2 <= '0;
      ov_p2  <= 1'b0;
      uf_p2  <= 1'b0;
      ix_p2  <= 1'b0;
    end else if (en) begin
      vld_p2 <= vld_p1;
      res_p2 <= res_s2;
      ov_p2  <= ov_s2;
      uf_p2  <= uf_s2;
      ix_p2  <= ix_s2;
    end
  end

  assign valid_o     = vld_p2;
  assign Result_o    = res_p2;
  assign Overflow_o  = ov_p2;
  assign Underflow_o = uf_p2;
  assign Inexact_o   = ix_p2;

endmodule

// File: tb/tb_fma_normalizer.sv
// Testbench for fma_normalizer: directed corner beats with fixed expectations,
// a backpressure burst, mid-flight reset, and randomized beats scored against
// a value-level rounding model.
module tb_fma_normalizer;

  logic        clk = 1'b0;
  logic        rst_i, valid_i, ready_o, Sign_i, Sticky_i, valid_o, ready_i;
  logic [74:0] Sum_i;
  logic [9:0]  Exp_i;
  logic [31:0] Result_o;
  logic        Overflow_o, Underflow_o, Inexact_o;

  fma_normalizer dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .Sum_i(Sum_i), .Exp_i(Exp_i), .Sign_i(Sign_i), .Sticky_i(Sticky_i),
    .valid_o(valid_o), .ready_i(ready_i), .Result_o(Result_o),
    .Overflow_o(Overflow_o), .Underflow_o(Underflow_o), .Inexact_o(Inexact_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [34:0] res;   // {overflow, underflow, inexact, result}
    int          cyc;
    bit          lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc   = 0;
  bit   bp_rand = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Reference: value-level round-to-nearest-even of Sum * 2^(Exp-bias-47).
  function automatic logic [34:0] model(input logic [74:0] s, input int ex,
                                        input logic sg, input logic st);
    int p, e, q;
    logic [127:0] m, rem, half, hid;
    logic up, ix;
    if (s == '0) return {1'b0, st, st, sg, 31'd0};
    p = 0;
    for (int i = 0; i < 75; i++) if (s[i]) p = i;
    e = ex + p - 47;
    if (e < 1) begin
`ifdef FMA_SUBNORMAL_EN
      if (ex + 26 < 0) return {3'b011, sg, 31'd0};
      q = 25 - ex;
      e = 1;
`else
      return {3'b011, sg, 31'd0};
`endif
    end else begin
      q = p - 23;
    end
    if (q <= 0) begin
      m = 128'(s) << (-q);
      rem = '0;
      half = '0;
    end else begin
      m = 128'(s) >> q;
      rem = 128'(s) & ((128'd1 << q) - 128'd1);
      half = 128'd1 << (q - 1);
    end
    ix = (rem != '0) | st;
    up = 1'b0;
    if (q > 0) begin
      if (rem > half) up = 1'b1;
      else if (rem == half && rem != '0) up = st | m[0];
    end
    m = m + 128'(up);
    hid = 128'd1 << 23;
    if (m >= (hid << 1)) begin
      m = m >> 1;
      e++;
    end
    if (m >= hid) begin
      if (e >= 255) return {3'b101, sg, 8'hFF, 23'd0};
      return {2'b00, ix, sg, 8'(e), 23'(m - hid)};
    end
    return {1'b0, ix, ix, sg, 8'd0, 23'(m)};
  endfunction

  function automatic logic [74:0] rand_sum();
    logic [74:0] r, one, mask;
    int p, k;
    r = 75'({$urandom(), $urandom(), $urandom()});
    k = int'($urandom_range(0, 9));
    if (k == 0) return '0;
    if (k < 4) r = r & 75'({$urandom(), $urandom(), $urandom()})
                   & 75'({$urandom(), $urandom(), $urandom()});
    p = int'($urandom_range(0, 74));
    one = 75'd1;
    mask = (one << p) - one;
    return (r & mask) | (one << p);
  endfunction

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [74:0] s, input logic [9:0] e, input logic sg,
                      input logic st, input logic [34:0] want, input bit lat);
    int w;
    exp_t item;
    valid_i = 1'b1; Sum_i = s; Exp_i = e; Sign_i = sg; Sticky_i = st;
    w = 0;
    @(negedge clk);
    while (!ready_o && w < 100) begin
      w++;
      @(negedge clk);
    end
    check("accept", 64'(ready_o), 64'd1);
    if (ready_o) begin
      item.res = want;
      item.cyc = cyc;
      item.lat = lat;
      exp_q.push_back(item);
    end
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask

  task automatic send_rand();
    logic [74:0] s;
    int ex;
    logic sg, st;
    s  = rand_sum();
    ex = int'($urandom_range(0, 340)) - 40;
    sg = 1'($urandom());
    st = ($urandom_range(0, 3) == 0);
    send(s, 10'(ex), sg, st, model(s, ex, sg, st), 1'b0);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 500) begin
      w++;
      @(negedge clk);
    end
    check("drain", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  // Output scoreboard: compare every valid cycle (so stalls verify hold), pop on transfer.
  always @(negedge clk) begin
    if (!rst_i && valid_o) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid", 64'(valid_o), 64'd0);
      end else begin
        check("beat", 64'({Overflow_o, Underflow_o, Inexact_o, Result_o}), 64'(exp_q[0].res));
        if (ready_i) begin
          if (exp_q[0].lat) check("latency", 64'(cyc - exp_q[0].cyc), 64'd3);
          exp_q.delete(0);
        end
      end
    end
  end

  // Random backpressure, changed just after the rising edge.
  always @(posedge clk) begin
    if (bp_rand) begin
      #1;
      ready_i = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_i = 1'b1; valid_i = 1'b0; Sum_i = '0; Exp_i = '0;
    Sign_i = 1'b0; Sticky_i = 1'b0; ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_i = 1'b0;
    @(negedge clk);
    check("rst_valid_o", 64'(valid_o), 64'd0);
    check("rst_result", 64'(Result_o), 64'd0);
    check("rst_flags", 64'({Overflow_o, Underflow_o, Inexact_o}), 64'd0);
    check("rst_ready_o", 64'(ready_o), 64'd1);
    @(posedge clk); #1;

    // Directed corners, constant expectations, latency checked on each.
    send(75'd1 << 47, 10'd127, 1'b0, 1'b0, {3'b000, 32'h3F800000}, 1'b1);
    send(75'd1 << 47, 10'd127, 1'b1, 1'b0, {3'b000, 32'hBF800000}, 1'b1);
    send((75'd1 << 74) | (75'd1 << 50), 10'd100, 1'b0, 1'b0, {3'b001, 32'h3F800000}, 1'b1);
    send((75'd1 << 74) | (75'd1 << 51) | (75'd1 << 50), 10'd100, 1'b0, 1'b0,
         {3'b001, 32'h3F800002}, 1'b1);
    send(75'h7FF_FFFC_0000_0000_0000, 10'd100, 1'b0, 1'b0, {3'b001, 32'h40000000}, 1'b1);
    send(75'd1 << 48, 10'd254, 1'b0, 1'b0, {3'b101, 32'h7F800000}, 1'b1);
`ifdef FMA_SUBNORMAL_EN
    send(75'd1 << 47, 10'd0, 1'b0, 1'b0, {3'b000, 32'h00400000}, 1'b1);
`else
    send(75'd1 << 47, 10'd0, 1'b0, 1'b0, {3'b011, 32'h00000000}, 1'b1);
`endif
    send(75'd0, 10'd50, 1'b1, 1'b0, {3'b000, 32'h80000000}, 1'b1);
    send(75'd0, 10'd50, 1'b0, 1'b1, {3'b011, 32'h00000000}, 1'b1);
    drain();

    // Backpressure burst: four beats while the sink refuses.
    ready_i = 1'b0;
    fork
      begin
        repeat (4) send_rand();
      end
      begin
        repeat (7) @(posedge clk);
        #1;
        check("stall_ready_o", 64'(ready_o), 64'd0);
        check("stall_valid_o", 64'(valid_o), 64'd1);
        ready_i = 1'b1;
      end
    join
    drain();

    // Reset with two beats in flight: nothing from them may emerge.
    send_rand();
    send_rand();
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    exp_q.delete();
    check("midrst_valid_o", 64'(valid_o), 64'd0);
    check("midrst_result", 64'(Result_o), 64'd0);
    check("midrst_ready_o", 64'(ready_o), 64'd1);
    repeat (8) begin
      @(negedge clk);
      check("midrst_idle", 64'(valid_o), 64'd0);
    end
    @(posedge clk); #1;

    // Randomized beats with random gaps and random backpressure.
    bp_rand = 1'b1;
    for (int n = 0; n < 400; n++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      send_rand();
    end
    bp_rand = 1'b0;
    @(posedge clk); #2;
    ready_i = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/fma_normalizer.md
# fma_normalizer

Post-addition normalize-and-round stage of the FMA datapath. Takes the 75-bit sum magnitude produced after the addend aligner and the wide adder, together with the aligned exponent, sign and shift-out sticky. Leading-zero counts, left-normalizes, rounds to nearest-even and packs an IEEE-754 result. Three-stage pipeline with valid/ready handshake on both sides; sits between the adder and the writeback register.

## Interface
- PARM_EXP, 8, exponent field width
- PARM_MANT, 23, stored mantissa width
- PARM_BIAS, 127, exponent bias
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- valid_i  in  1  input beat valid
- ready_o  out  1  stage accepts input this cycle
- Sum_i  in  3*PARM_MANT+6 (75)  unsigned sum magnitude, already complemented upstream
- Exp_i  in  PARM_EXP+2 (10)  two's-complement aligned exponent, matches upstream Exp_aligned width
- Sign_i  in  1  result sign, resolved upstream
- Sticky_i  in  1  OR of addend bits shifted out by the aligner
- valid_o  out  1  result valid
- ready_i  in  1  downstream accepts result
- Result_o  out  PARM_EXP+PARM_MANT+1 (32)  packed sign/exponent/mantissa
- Overflow_o, Underflow_o, Inexact_o  out  1 each  IEEE flags for the beat on Result_o

## Operation
- Weighting: leading one at bit 2*PARM_MANT+1 (47) with Exp_i=E means biased exponent E. With leading one at p = 74-lzc, e = Exp_i + 27 - lzc (10-bit signed).
- S1: register Sum_i, Exp_i, Sign_i, Sticky_i, lzc (0..75), zero flag (Sum_i==0).
- S2: shift amount sh = lzc if e >= 1; otherwise subnormal path (see Configuration). Left shift Sum by sh; e_final = Exp_i + 27 - sh.
- S3: L = bit 51, G = bit 50, S = |bits[49:0] | Sticky. Round up iff G & (L | S). Mantissa = bits[74:51] + up (25-bit). Carry out → e_final+1, mantissa field 0.
- Exponent field = e_final if hidden bit (bit 74 post-round) set, else 0.
- e_final >= 255 after rounding → ±inf (0x7F800000 | sign), Overflow_o=1, Inexact_o=1.
- Inexact_o = G | S (or overflow). Underflow_o = result subnormal/zero and inexact.
- Zero sum: Sum_i==0 and Sticky_i==0 → Result_o = {Sign_i, 0}, no flags. Sum_i==0 with Sticky_i=1 → {Sign_i, 0}, Inexact_o=1, Underflow_o=1.

## Timing
- Latency 3 cycles input-accept to valid_o; throughput 1 beat/cycle.
- Global stall: en = ~valid_o | ready_i; ready_o = en. All stage registers (data and valid) load only when en.
- Input transfers when valid_i & ready_o; output transfers when valid_o & ready_i.
- Result_o and flags stable while valid_o & ~ready_i.
- Reset: all stage valids 0; valid_o=0, Result_o=0, all flags 0; ready_o=1 in the first cycle after reset. Reset mid-operation discards all in-flight beats, no partial output.
- Simultaneous accept and emit with ready_i=1: both occur, pipeline advances.

## Configuration
- FMA_SUBNORMAL_EN defined: when e < 1, sh = clamp(Exp_i+26, 0, lzc); if Exp_i+26 < 0 and Sum nonzero, result ±0 with Inexact_o=Underflow_o=1. Rounding can carry a subnormal into exponent 1.
- Undefined: any beat with e < 1 flushes to {Sign_i, 0}, Underflow_o=1, Inexact_o=1; no subnormal results produced.

## Test plan
- Sum_i=1<<47, Exp_i=127, Sign_i=0 → 3 cycles later Result_o=0x3F800000, flags 0.
- Sum_i=(1<<74)|(1<<50), Exp_i=100 → 0x3F800000, Inexact_o=1 (tie, even); Sum_i=(1<<74)|(1<<51)|(1<<50) → 0x3F800002, Inexact_o=1.
- Sum_i=1<<48, Exp_i=254 → 0x7F800000, Overflow_o=1, Inexact_o=1.
- Sum_i=1<<47, Exp_i=0 → with FMA_SUBNORMAL_EN 0x00400000, no flags; without → 0x00000000, Underflow_o=Inexact_o=1.
- Issue 4 back-to-back beats, hold ready_i=0 → ready_o drops once valid_o=1, Result_o holds beat 1; release ready_i → beats emerge in order, one per cycle, none lost.
- Assert rst_i for 1 cycle with 2 beats in flight → valid_o=0 next cycle, Result_o=0, no stale result emitted afterwards.
